// File: rtl/core_pkg.sv
// Shared definitions for the load/store path: funct3 encodings, access
// size and FSM state enums, and the load lane extraction helper.
package core_pkg;

    // funct3 encodings for loads and stores (Instruction_out[14:12])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Pick the addressed byte/half out of a read word and extend it.
    // Halfword offsets are assumed aligned, so only off[1] selects the half.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] rdata,
        input size_e       size,
        input logic        sign,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    r = {{24{sign & b[7]}}, b};
            SZ_H:    r = {{16{sign & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between the core and a 32-bit word memory.
// Store side builds byte enables and replicated write data; load side
// extracts and extends the addressed lane of a read word.
module lsu_lane_align
    import core_pkg::*;
(
    input  size_e       st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  size_e       ld_size_i,
    input  logic        ld_sign_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    // Store lanes: shift the enable pattern to the offset, replicate the data
    always_comb begin
        wstrb_o = 4'hF;
        wdata_o = st_data_i;
        case (st_size_i)
            SZ_B: begin
                wstrb_o = 4'b0001 << st_off_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                wstrb_o = 4'b0011 << st_off_i;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'hF;
                wdata_o = st_data_i;
            end
        endcase
    end

    assign ld_data_o = lane_extract(rdata_i, ld_size_i, ld_sign_i, ld_off_i);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: decodes a load/store, runs one req/ready transaction
// with data memory (with a timeout), and returns extended load data with a
// one-cycle done pulse. stall holds the PC while the access is in flight.
//
// Memory handshake: mem_req rises on entry to REQ and is held, with
// mem_we/mem_addr/mem_wstrb/mem_wdata frozen, until the cycle in which
// mem_ready=1 (transfer happens on that clock edge, mem_rdata sampled in the
// same cycle); it only otherwise falls on timeout or reset.
module load_store_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Memread,
    input  logic              Memwrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              done,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state_o
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    size_e         size_q;
    logic          sign_q;
    logic [1:0]    off_q;

    logic        op_any;
    size_e       dec_size;
    logic        dec_sign;
    logic        dec_legal;
    logic        dec_mis;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_ext;

    assign op_any      = Memread | Memwrite;
    assign stall       = (state_q != ST_DONE) & op_any;
    assign dbg_state_o = state_q;

    // Decode funct3 into size/sign and legality for the requested direction
    always_comb begin
        dec_size  = SZ_B;
        dec_sign  = 1'b0;
        dec_legal = 1'b0;
        case (funct3)
            F3_B:  begin dec_size = SZ_B; dec_sign = 1'b1; dec_legal = 1'b1;    end
            F3_H:  begin dec_size = SZ_H; dec_sign = 1'b1; dec_legal = 1'b1;    end
            F3_W:  begin dec_size = SZ_W; dec_sign = 1'b1; dec_legal = 1'b1;    end
            F3_BU: begin dec_size = SZ_B; dec_sign = 1'b0; dec_legal = Memread; end
            F3_HU: begin dec_size = SZ_H; dec_sign = 1'b0; dec_legal = Memread; end
            default: dec_legal = 1'b0;
        endcase
        if (Memread & Memwrite) begin
            dec_legal = 1'b0;
        end
        dec_mis = ((dec_size == SZ_H) & addr[0]) |
                  ((dec_size == SZ_W) & (|addr[1:0]));
    end

    lsu_lane_align u_align (
        .st_size_i (dec_size),
        .st_off_i  (addr[1:0]),
        .st_data_i (store_data),
        .wstrb_o   (st_wstrb),
        .wdata_o   (st_wdata),
        .ld_size_i (size_q),
        .ld_sign_i (sign_q),
        .ld_off_i  (off_q),
        .rdata_i   (mem_rdata),
        .ld_data_o (ld_ext)
    );

    // Access FSM with timeout counter; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            size_q     <= SZ_B;
            sign_q     <= 1'b0;
            off_q      <= 2'b00;
            load_data  <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_any) begin
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_we    <= Memwrite;
                        mem_wstrb <= Memwrite ? st_wstrb : 4'h0;
                        mem_wdata <= Memwrite ? st_wdata : 32'h0;
                        size_q    <= dec_size;
                        sign_q    <= dec_sign;
                        off_q     <= addr[1:0];
                        cnt_q     <= '0;
                        if (!dec_legal) begin
                            // Illegal op wins over misalignment
                            state_q   <= ST_DONE;
                            done      <= 1'b1;
                            bus_error <= 1'b1;
                            load_data <= '0;
                        end else if (dec_mis) begin
                            state_q    <= ST_DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                            load_data  <= '0;
                        end else begin
                            state_q <= ST_REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        state_q   <= ST_DONE;
                        done      <= 1'b1;
                        load_data <= mem_we ? 32'h0 : ld_ext;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        state_q   <= ST_DONE;
                        done      <= 1'b1;
                        bus_error <= 1'b1;
                        load_data <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    bus_error  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of access vectors with
// hand-computed results, plus a reset-during-request sequence.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        Memread;
    logic        Memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        misaligned;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .Memread     (Memread),
        .Memwrite    (Memwrite),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .load_data   (load_data),
        .done        (done),
        .stall       (stall),
        .misaligned  (misaligned),
        .bus_error   (bus_error),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ready_after;  // REQ cycle in which mem_ready is given, 0 = never
        int          exp_req;      // cycles mem_req is high
        int          exp_lat;      // clock edges from op applied to done visible
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        logic        exp_mis;
        logic        exp_berr;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(string n, logic rd, logic wr, logic [2:0] f3,
                                logic [31:0] a, logic [31:0] sd, logic [31:0] rdat,
                                int ra, int er, int el, logic [3:0] ws,
                                logic [31:0] ma, logic [31:0] wd, logic [31:0] ld,
                                logic mi, logic be);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sd = sd;
        v.rdata = rdat; v.ready_after = ra; v.exp_req = er; v.exp_lat = el;
        v.exp_wstrb = ws; v.exp_maddr = ma; v.exp_wdata = wd; v.exp_load = ld;
        v.exp_mis = mi; v.exp_berr = be;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply one access, play the memory side, and check everything up to
    // one cycle past done
    task automatic run_vec(input vec_t v);
        int  req_n;
        int  edges;
        bit  got;
        req_n = 0;
        edges = 0;
        got   = 1'b0;
        @(negedge clk);
        Memread    = v.rd;
        Memwrite   = v.wr;
        funct3     = v.f3;
        addr       = v.addr;
        store_data = v.sd;
        mem_ready  = 1'b0;
        #1;
        chk({v.name, ".stall_first"}, 32'(stall), 32'd1);
        while (!got && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                req_n++;
                chk({v.name, ".mem_we"}, 32'(mem_we), 32'(v.wr));
                chk({v.name, ".mem_addr"}, mem_addr, v.exp_maddr);
                chk({v.name, ".mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
                if (v.wr) chk({v.name, ".mem_wdata"}, mem_wdata, v.exp_wdata);
                chk({v.name, ".stall_req"}, 32'(stall), 32'd1);
                if (v.ready_after != 0 && req_n == v.ready_after) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end
            end else if (done) begin
                got = 1'b1;
            end
        end
        if (!got) begin
            failures++;
            checks++;
            $display("FAIL %s.done_timeout: no done within %0d cycles", v.name, edges);
        end else begin
            chk({v.name, ".latency"}, 32'(edges), 32'(v.exp_lat));
            chk({v.name, ".req_cycles"}, 32'(req_n), 32'(v.exp_req));
            chk({v.name, ".stall_done"}, 32'(stall), 32'd0);
            chk({v.name, ".load_data"}, load_data, v.exp_load);
            chk({v.name, ".misaligned"}, 32'(misaligned), 32'(v.exp_mis));
            chk({v.name, ".bus_error"}, 32'(bus_error), 32'(v.exp_berr));
        end
        Memread  = 1'b0;
        Memwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({v.name, ".done_pulse"}, 32'(done), 32'd0);
        chk({v.name, ".flags_clear"}, 32'({misaligned, bus_error}), 32'd0);
        chk({v.name, ".load_hold"}, load_data, v.exp_load);
        chk({v.name, ".state_idle"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk("lw_aligned",  1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1, 2,  4'h0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0);
        vecs[1]  = mk("lb_signed",   1, 0, 3'b000, 32'h203, 32'h0,        32'h80FF0000, 1, 1, 2,  4'h0, 32'h200, 32'h0,        32'hFFFFFF80, 0, 0);
        vecs[2]  = mk("lbu",         1, 0, 3'b100, 32'h203, 32'h0,        32'h80FF0000, 1, 1, 2,  4'h0, 32'h200, 32'h0,        32'h00000080, 0, 0);
        vecs[3]  = mk("sh_wait3",    0, 1, 3'b001, 32'h012, 32'h0000ABCD, 32'h0,        3, 3, 4,  4'hC, 32'h010, 32'hABCDABCD, 32'h0,        0, 0);
        vecs[4]  = mk("lw_misal",    1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 1,  4'h0, 32'h100, 32'h0,        32'h0,        1, 0);
        vecs[5]  = mk("ld_f3_011",   1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0, 1,  4'h0, 32'h100, 32'h0,        32'h0,        0, 1);
        vecs[6]  = mk("sw_timeout",  0, 1, 3'b010, 32'h040, 32'h12345678, 32'h0,        0, 16, 17, 4'hF, 32'h040, 32'h12345678, 32'h0,       0, 1);
        vecs[7]  = mk("sw_wait2",    0, 1, 3'b010, 32'h044, 32'hCAFEF00D, 32'h0,        2, 2, 3,  4'hF, 32'h044, 32'hCAFEF00D, 32'h0,        0, 0);
        vecs[8]  = mk("lh_signed",   1, 0, 3'b001, 32'h206, 32'h0,        32'h80017FFF, 1, 1, 2,  4'h0, 32'h204, 32'h0,        32'hFFFF8001, 0, 0);
        vecs[9]  = mk("lhu",         1, 0, 3'b101, 32'h204, 32'h0,        32'h8001F00F, 1, 1, 2,  4'h0, 32'h204, 32'h0,        32'h0000F00F, 0, 0);
        vecs[10] = mk("sb_off1",     0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1, 1, 2,  4'h2, 32'h300, 32'hA5A5A5A5, 32'h0,        0, 0);
        vecs[11] = mk("rd_and_wr",   1, 1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 0, 1,  4'h0, 32'h100, 32'h0,        32'h0,        0, 1);
        vecs[12] = mk("lh_misal",    1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 0, 1,  4'h0, 32'h100, 32'h0,        32'h0,        1, 0);
        vecs[13] = mk("st_bad_misal",0, 1, 3'b100, 32'h103, 32'h0,        32'h0,        0, 0, 1,  4'h0, 32'h100, 32'h0,        32'h0,        0, 1);
        vecs[14] = mk("lb_off1",     1, 0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 1, 1, 2,  4'h0, 32'h000, 32'h0,        32'h0000007F, 0, 0);

        // Reset
        rst        = 1'b0;
        Memread    = 1'b0;
        Memwrite   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.outputs", {load_data[15:0], 11'd0, done, stall, misaligned, bus_error, mem_req}, 32'd0);
        chk("reset.mem_bus", {mem_addr[15:0], mem_wdata[11:0], mem_wstrb}, 32'd0);
        chk("reset.state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle.no_op_done", 32'(done), 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while a request is outstanding
        @(negedge clk);
        Memread = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h100;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req.before", 32'(mem_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_req.req_drop", 32'(mem_req), 32'd0);
        chk("rst_req.no_done", 32'(done), 32'd0);
        chk("rst_req.state", 32'(dbg_state), 32'd0);
        Memread = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req.still_no_done", 32'(done), 32'd0);
        rst = 1'b1;
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
